vic_responder: RTL and testbench

- Vectored interrupt controller. It is the device-side responder to the CPU board's vector-fetch handshake (irq / istb / ivec / iack).
- Collects level requests from up to N peripherals on one priority level and raises a single irq to the CPU.
- When the CPU strobes for a vector, it arbitrates, returns the winner's 9-bit vector with an acknowledge, and pulses a per-device acknowledge.
- One instance is placed per priority level (4, 5), between the peripheral set and the CPU board.

---
 rtl/vic_pkg.sv | 22 ++
 rtl/vic_prio_enc.sv | 31 +++
 rtl/vic_responder.sv | 110 +++++++++++
 tb/tb_vic_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vic_pkg.sv
// Shared types and helpers for the vectored interrupt responder.
package vic_pkg;

  localparam int VEC_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Combinational N-input priority encoder; scan starts at 'start' and wraps mod N.
module vic_prio_enc #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] sel,
  output logic             any
);

  int   idx;
  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        sel   = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/vic_responder.sv
// Vectored interrupt responder for one priority level (irq/istb/ivec/iack handshake).
// Define VIC_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index-wins.
module vic_responder
  import vic_pkg::*;
#(
  parameter int                 N        = 8,
  parameter logic [N*VEC_W-1:0] VEC_LIST = '0,
  parameter logic [VEC_W-1:0]   NULL_VEC = 9'o000
) (
  input  logic             clk_p,
  input  logic             rst_n,
  input  logic [N-1:0]     ireq_i,
  output logic [N-1:0]     iack_dev_o,
  output logic             irq_o,
  input  logic             istb_i,
  output logic [VEC_W-1:0] ivec_o,
  output logic             iack_o,
  output logic             busy_o
);

  localparam int SEL_W = (N > 1) ? clog2(N) : 1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               null_q, null_d;
  logic               iack_d, irq_d;
  logic [VEC_W-1:0]   ivec_d;
  logic [N-1:0]       dev_d;
  logic [SEL_W-1:0]   enc_start, enc_sel;
  logic               enc_any;

  function automatic logic [VEC_W-1:0] vec_of(input logic [SEL_W-1:0] s);
    return VEC_LIST[VEC_W*int'(s) +: VEC_W];
  endfunction

`ifdef VIC_ROUND_ROBIN_EN
  logic [SEL_W-1:0] last_q;

  assign enc_start = (last_q == SEL_W'(N-1)) ? '0 : last_q + 1'b1;

  // Pointer resets to N-1 so the first pass starts at source 0.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n)                         last_q <= SEL_W'(N-1);
    else if (state_q == LATCH && enc_any) last_q <= enc_sel;
  end
`else
  assign enc_start = '0;
`endif

  vic_prio_enc #(.N(N), .SEL_W(SEL_W)) u_enc (
    .req   (ireq_i),
    .start (enc_start),
    .sel   (enc_sel),
    .any   (enc_any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    null_d  = null_q;
    iack_d  = 1'b0;
    ivec_d  = '0;
    dev_d   = '0;
    irq_d   = (state_q == IDLE) && (|ireq_i);
    case (state_q)
      IDLE: if (istb_i) state_d = LATCH;
      LATCH: begin
        sel_d   = enc_sel;
        null_d  = ~enc_any;
        iack_d  = 1'b1;
        ivec_d  = enc_any ? vec_of(enc_sel) : NULL_VEC;
        if (enc_any) dev_d = N'(1) << enc_sel;
        state_d = ACK;
      end
      ACK: begin
        if (istb_i) begin
          iack_d = 1'b1;
          ivec_d = null_q ? NULL_VEC : vec_of(sel_q);
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      null_q     <= 1'b0;
      irq_o      <= 1'b0;
      iack_o     <= 1'b0;
      ivec_o     <= '0;
      iack_dev_o <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      null_q     <= null_d;
      irq_o      <= irq_d;
      iack_o     <= iack_d;
      ivec_o     <= ivec_d;
      iack_dev_o <= dev_d;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_vic_responder.sv
// Directed self-checking bench for vic_responder (N=8).
module tb_vic_responder;
  localparam int N = 8;
  localparam logic [N*9-1:0] VLIST = {9'o210, 9'o170, 9'o150, 9'o130,
                                      9'o110, 9'o070, 9'o100, 9'o060};
  localparam logic [8:0] NVEC = 9'o774;

  logic         clk_p = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] ireq_i = '0;
  logic [N-1:0] iack_dev_o;
  logic         irq_o, istb_i = 1'b0, iack_o, busy_o;
  logic [8:0]   ivec_o;
  int checks = 0;
  int errors = 0;

  vic_responder #(.N(N), .VEC_LIST(VLIST), .NULL_VEC(NVEC)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .ireq_i(ireq_i), .iack_dev_o(iack_dev_o),
    .irq_o(irq_o), .istb_i(istb_i), .ivec_o(ivec_o), .iack_o(iack_o), .busy_o(busy_o)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_p);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; istb_i = 1'b0; ireq_i = '0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  // Full handshake: strobe, capture first ACK cycle, release, return to IDLE.
  task automatic handshake(output logic ack, output logic [8:0] vec, output logic [N-1:0] dev);
    istb_i = 1'b1;
    tick(2);
    ack = iack_o; vec = ivec_o; dev = iack_dev_o;
    istb_i = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    checks++; if (iack_o !== 1'b0) begin errors++; $display("FAIL reset_iack got=%b exp=0", iack_o); end
    checks++; if (ivec_o !== 9'd0) begin errors++; $display("FAIL reset_ivec got=%o exp=0", ivec_o); end
    checks++; if (iack_dev_o !== 8'h00) begin errors++; $display("FAIL reset_dev got=%h exp=00", iack_dev_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    ireq_i = 8'h04;
    #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL single_irq_pre got=%b exp=0", irq_o); end
    tick();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL single_irq_lat got=%b exp=1", irq_o); end
    istb_i = 1'b1;
    tick();
    checks++; if (iack_o !== 1'b0) begin errors++; $display("FAIL single_iack_early got=%b exp=0", iack_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy_o); end
    tick();
    checks++; if (iack_o !== 1'b1) begin errors++; $display("FAIL single_iack got=%b exp=1", iack_o); end
    checks++; if (ivec_o !== 9'o070) begin errors++; $display("FAIL single_ivec got=%o exp=070", ivec_o); end
    checks++; if (iack_dev_o !== 8'h04) begin errors++; $display("FAIL single_dev got=%h exp=04", iack_dev_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL single_irq_ack got=%b exp=0", irq_o); end
    ireq_i = 8'h05;
    tick();
    checks++; if (iack_dev_o !== 8'h00) begin errors++; $display("FAIL single_dev_pulse got=%h exp=00", iack_dev_o); end
    checks++; if (ivec_o !== 9'o070) begin errors++; $display("FAIL single_ivec_hold got=%o exp=070", ivec_o); end
    checks++; if (iack_o !== 1'b1) begin errors++; $display("FAIL single_iack_hold got=%b exp=1", iack_o); end
    istb_i = 1'b0;
    tick();
    checks++; if (iack_o !== 1'b0) begin errors++; $display("FAIL single_iack_clr got=%b exp=0", iack_o); end
    checks++; if (ivec_o !== 9'd0) begin errors++; $display("FAIL single_ivec_clr got=%o exp=0", ivec_o); end
    tick();
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL single_irq_rel got=%b exp=0", irq_o); end
    tick();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL single_irq_back got=%b exp=1", irq_o); end
    ireq_i = '0;
    tick(2);
  endtask

  task automatic test_simultaneous();
    logic ack; logic [8:0] vec; logic [N-1:0] dev;
    do_reset();
    ireq_i = 8'h82;
    tick();
    handshake(ack, vec, dev);
    checks++; if (vec !== 9'o100) begin errors++; $display("FAIL simul1_ivec got=%o exp=100", vec); end
    checks++; if (dev !== 8'h02) begin errors++; $display("FAIL simul1_dev got=%h exp=02", dev); end
    ireq_i = 8'h80;
    tick();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL simul_irq_again got=%b exp=1", irq_o); end
    handshake(ack, vec, dev);
    checks++; if (vec !== 9'o210) begin errors++; $display("FAIL simul2_ivec got=%o exp=210", vec); end
    checks++; if (dev !== 8'h80) begin errors++; $display("FAIL simul2_dev got=%h exp=80", dev); end
    ireq_i = '0;
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic ack; logic [8:0] vec; logic [N-1:0] dev;
    logic [8:0] exp_vec [4];
    do_reset();
`ifdef VIC_ROUND_ROBIN_EN
    exp_vec = '{9'o060, 9'o100, 9'o060, 9'o100};
`else
    exp_vec = '{9'o060, 9'o060, 9'o060, 9'o060};
`endif
    ireq_i = 8'h03;
    tick();
    for (int k = 0; k < 4; k++) begin
      handshake(ack, vec, dev);
      checks++; if (vec !== exp_vec[k]) begin errors++; $display("FAIL b2b_ivec[%0d] got=%o exp=%o", k, vec, exp_vec[k]); end
    end
    ireq_i = '0;
    tick(2);
  endtask

  task automatic test_withdrawn();
    logic ack; logic [8:0] vec; logic [N-1:0] dev;
    do_reset();
    ireq_i = 8'h04;
    tick();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL wd_irq got=%b exp=1", irq_o); end
    ireq_i = '0;
    handshake(ack, vec, dev);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wd_iack got=%b exp=1", ack); end
    checks++; if (vec !== NVEC) begin errors++; $display("FAIL wd_ivec got=%o exp=%o", vec, NVEC); end
    checks++; if (dev !== 8'h00) begin errors++; $display("FAIL wd_dev got=%h exp=00", dev); end
  endtask

  task automatic test_reset_mid_ack();
    do_reset();
    ireq_i = 8'h01;
    tick();
    istb_i = 1'b1;
    tick(2);
    checks++; if (iack_o !== 1'b1) begin errors++; $display("FAIL rma_iack_pre got=%b exp=1", iack_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (iack_o !== 1'b0) begin errors++; $display("FAIL rma_iack got=%b exp=0", iack_o); end
    checks++; if (ivec_o !== 9'd0) begin errors++; $display("FAIL rma_ivec got=%o exp=0", ivec_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rma_irq got=%b exp=0", irq_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rma_busy got=%b exp=0", busy_o); end
    istb_i = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL rma_irq_back got=%b exp=1", irq_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rma_idle got=%b exp=0", busy_o); end
    ireq_i = '0;
    tick(2);
  endtask

  task automatic test_early_drop();
    do_reset();
    ireq_i = 8'h04;
    tick();
    istb_i = 1'b1;
    tick();
    istb_i = 1'b0;
    tick();
    checks++; if (iack_o !== 1'b1) begin errors++; $display("FAIL ed_iack got=%b exp=1", iack_o); end
    checks++; if (ivec_o !== 9'o070) begin errors++; $display("FAIL ed_ivec got=%o exp=070", ivec_o); end
    checks++; if (iack_dev_o !== 8'h04) begin errors++; $display("FAIL ed_dev got=%h exp=04", iack_dev_o); end
    ireq_i = '0;
    tick();
    checks++; if (iack_o !== 1'b0) begin errors++; $display("FAIL ed_iack_clr got=%b exp=0", iack_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ed_release got=%b exp=1", busy_o); end
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ed_idle got=%b exp=0", busy_o); end
    tick();
    checks++; if (iack_o !== 1'b0) begin errors++; $display("FAIL ed_no_stuck got=%b exp=0", iack_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_withdrawn();
    test_reset_mid_ack();
    test_early_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
